// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - register file port bundle (decode reads, writeback write, optional reservations)
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] dout;
  logic [NUM_RD-1:0]        dvalid;
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        din;
`ifdef REGFILE_SCOREBOARD_EN
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_RD-1:0]        rd_busy;

  modport master (output rd_en, rd_addr, we, wr_addr, din, rsv_en, rsv_addr,
                  input  dout, dvalid, rd_busy);
  modport slave  (input  rd_en, rd_addr, we, wr_addr, din, rsv_en, rsv_addr,
                  output dout, dvalid, rd_busy);
`else
  modport master (output rd_en, rd_addr, we, wr_addr, din,
                  input  dout, dvalid);
  modport slave  (input  rd_en, rd_addr, we, wr_addr, din,
                  output dout, dvalid);
`endif
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with write bypass; busy scoreboard under REGFILE_SCOREBOARD_EN
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_mp_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] rd_word  [NUM_RD];
  logic [ADDR_W-1:0] rd_a     [NUM_RD];
  logic [DATA_W-1:0] dout_q   [NUM_RD];
  logic [NUM_RD-1:0] dvalid_q;
  logic              wr_ok;

  assign wr_ok = rf.we && !(ZR && rf.wr_addr == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (wr_ok) begin
      mem[rf.wr_addr] <= rf.din;
    end
  end

  // Same-edge write to the read address forwards din so decode never sees stale data
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_a[i]    = rf.rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_word[i] = (ZR && rd_a[i] == '0)             ? '0     :
                        (wr_ok && rf.wr_addr == rd_a[i]) ? rf.din :
                                                            mem[rd_a[i]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RD; i++) dout_q[i] <= '0;
      dvalid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        dvalid_q[i] <= rf.rd_en[i];
        if (rf.rd_en[i]) dout_q[i] <= rd_word[i];
      end
    end
  end

  always_comb begin
    rf.dout = '0;
    for (int i = 0; i < NUM_RD; i++) rf.dout[i*DATA_W +: DATA_W] = dout_q[i];
  end
  assign rf.dvalid = dvalid_q;

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [NUM_RD-1:0] rd_busy_q;

  // Reservation is applied after the writeback clear so a same-address pair leaves the bit set
  always_comb begin
    busy_nxt = busy;
    if (rf.we) busy_nxt[rf.wr_addr] = 1'b0;
    if (rf.rsv_en && !(ZR && rf.rsv_addr == '0)) busy_nxt[rf.rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= '0;
      rd_busy_q <= '0;
    end else begin
      busy <= busy_nxt;
      for (int i = 0; i < NUM_RD; i++)
        if (rf.rd_en[i]) rd_busy_q[i] <= busy_nxt[rd_a[i]];
    end
  end

  assign rf.rd_busy = rd_busy_q;
`endif
endmodule
